// File: rtl/squeeze_output_unit.sv
// squeeze_output_unit
// Squeeze side of the SHAKE core. Reads rate lanes out of the Keccak state and
// streams exactly output_length bytes as 64-bit words over a valid/ready
// interface. Bytes are MSB-first, and the unused bytes of the final word are
// zeroed. When a rate block runs out and more output is still owed, the unit
// asks the core for another permutation.
//
// Optional feature: define SQUEEZE_XOF_UNBOUNDED_EN to add a 'stop' input.
// In that build, output_length==0 selects unbounded XOF streaming, and a stop
// pulse makes the next loaded word the final one.
//
// Stream handshake: a word transfers on a rising clock edge where
// data_out_valid && data_out_ready. While valid is high and ready is low,
// data_out, last_word and last_valid_bytes hold their values.

package keccak_pkg;
    localparam int W            = 64;
    localparam int W_BYTE_SIZE  = 8;
    localparam int W_BYTE_WIDTH = 3;
endpackage

module squeeze_output_unit
    import keccak_pkg::*;
#(
    parameter int LEN_WIDTH      = 32,
    parameter int RATE_IDX_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      output_length,
    input  logic [RATE_IDX_WIDTH-1:0] rate_words,
    input  logic                      state_ready,
    output logic [RATE_IDX_WIDTH-1:0] word_index,
    input  logic [W-1:0]              state_word,
    output logic [W-1:0]              data_out,
    output logic                      data_out_valid,
    input  logic                      data_out_ready,
    output logic                      last_word,
    output logic [W_BYTE_WIDTH-1:0]   last_valid_bytes,
    output logic                      permute_request,
    input  logic                      permute_done,
`ifdef SQUEEZE_XOF_UNBOUNDED_EN
    input  logic                      stop,
`endif
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_STATE = 2'd1,
        EMIT       = 2'd2,
        PERMUTE    = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] WORD_BYTES = LEN_WIDTH'(W_BYTE_SIZE);

    state_t                    state;
    logic [LEN_WIDTH-1:0]      bytes_left;
    logic [RATE_IDX_WIDTH-1:0] rate_q;

    logic                      handshake;
    logic [LEN_WIDTH-1:0]      bytes_after;
    logic [LEN_WIDTH-1:0]      load_remaining;
    logic                      load_last_len;
    logic                      load_last;
    logic [W_BYTE_WIDTH-1:0]   load_lvb;
    logic [W-1:0]              keep_mask;
    logic [W-1:0]              load_word;

`ifdef SQUEEZE_XOF_UNBOUNDED_EN
    logic                      unbounded;
    logic                      stop_pending;
`endif

    // Byte accounting for the word about to be loaded into data_out.
    // In WAIT_STATE the next word is the first one of the block, so bytes_left
    // already counts it. In EMIT the load happens as the current word is
    // accepted, so the count for the new word is bytes_left minus one word.
    always_comb begin
        handshake      = data_out_valid && data_out_ready;
        bytes_after    = (bytes_left > WORD_BYTES) ? (bytes_left - WORD_BYTES) : '0;
        load_remaining = (state == EMIT) ? bytes_after : bytes_left;
        load_last_len  = (load_remaining <= WORD_BYTES);
`ifdef SQUEEZE_XOF_UNBOUNDED_EN
        if (unbounded) begin
            load_last = stop_pending || stop;
            load_lvb  = '0;
        end else begin
            load_last = load_last_len;
            load_lvb  = load_last_len ? load_remaining[W_BYTE_WIDTH-1:0] : '0;
        end
`else
        load_last = load_last_len;
        // A full final word leaves the low bits at 0, which encodes "all bytes valid".
        load_lvb  = load_last_len ? load_remaining[W_BYTE_WIDTH-1:0] : '0;
`endif
    end

    // Zero the trailing bytes of a partial final word. Byte 0 is the MSB byte,
    // so the kept bytes form a mask of ones anchored at the top of the word.
    always_comb begin
        keep_mask = '1;
        if (load_lvb != '0) begin
            keep_mask = ~({W{1'b1}} >> {load_lvb, 3'b000});
        end
        load_word = state_word & keep_mask;
    end

    // Main controller. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bytes_left       <= '0;
            rate_q           <= '0;
            word_index       <= '0;
            data_out         <= '0;
            data_out_valid   <= 1'b0;
            last_word        <= 1'b0;
            last_valid_bytes <= '0;
            permute_request  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
`ifdef SQUEEZE_XOF_UNBOUNDED_EN
            unbounded        <= 1'b0;
            stop_pending     <= 1'b0;
`endif
        end else begin
            done            <= 1'b0;
            permute_request <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (output_length == '0) begin
`ifdef SQUEEZE_XOF_UNBOUNDED_EN
                            // Zero length selects unbounded streaming.
                            unbounded    <= 1'b1;
                            stop_pending <= 1'b0;
                            bytes_left   <= '0;
                            rate_q       <= rate_words;
                            word_index   <= '0;
                            busy         <= 1'b1;
                            state        <= WAIT_STATE;
`else
                            // Nothing to emit; finish right away.
                            done <= 1'b1;
`endif
                        end else begin
`ifdef SQUEEZE_XOF_UNBOUNDED_EN
                            unbounded    <= 1'b0;
                            stop_pending <= 1'b0;
`endif
                            bytes_left <= output_length;
                            rate_q     <= rate_words;
                            word_index <= '0;
                            busy       <= 1'b1;
                            state      <= WAIT_STATE;
                        end
                    end
                end

                WAIT_STATE: begin
                    if (state_ready) begin
                        data_out         <= load_word;
                        last_word        <= load_last;
                        last_valid_bytes <= load_lvb;
                        data_out_valid   <= 1'b1;
                        word_index       <= word_index + 1'b1;
                        state            <= EMIT;
                    end
                end

                EMIT: begin
                    if (handshake) begin
                        bytes_left <= bytes_after;
                        if (last_word) begin
                            // The final word is checked before block exhaustion,
                            // so an exact multiple of the rate never requests a
                            // trailing permutation.
                            data_out         <= '0;
                            data_out_valid   <= 1'b0;
                            last_word        <= 1'b0;
                            last_valid_bytes <= '0;
                            word_index       <= '0;
                            busy             <= 1'b0;
                            done             <= 1'b1;
                            state            <= IDLE;
                        end else if (word_index == rate_q) begin
                            data_out_valid   <= 1'b0;
                            last_word        <= 1'b0;
                            last_valid_bytes <= '0;
                            permute_request  <= 1'b1;
                            state            <= PERMUTE;
                        end else begin
                            // Back-to-back load keeps one word per cycle inside a block.
                            data_out         <= load_word;
                            last_word        <= load_last;
                            last_valid_bytes <= load_lvb;
                            word_index       <= word_index + 1'b1;
                        end
                    end
                end

                PERMUTE: begin
                    if (permute_done) begin
                        word_index <= '0;
                        state      <= WAIT_STATE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef SQUEEZE_XOF_UNBOUNDED_EN
            // Remember a stop that arrives while no word is being loaded.
            if (unbounded && stop && (state != IDLE)) begin
                stop_pending <= 1'b1;
            end
`endif
        end
    end

endmodule
